// File: rtl/mux4x1_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux4x1_pkg;

    localparam int NREQ = 4;

    typedef enum logic {IDLE, OWN} arb_state_t;
    typedef logic [1:0] idx_t;

    function automatic logic [NREQ-1:0] idx_onehot(input idx_t idx);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4x1_arb_rr_pick4.sv
// Combinational cyclic search: first set request bit starting at index start.
module rr_pick4
    import mux4x1_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            start,
    output logic            found,
    output idx_t            winner
);

    idx_t cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        found  = 1'b0;
        winner = start;
        cand   = start;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = start + idx_t'(k);
            if (req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/mux4x1_arb.sv
// Round-robin arbiter sharing one 4:1 mux; registered one-hot grant, select and enable.
module mux4x1_arb
    import mux4x1_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] GNT,
    output idx_t            SEL,
    output logic            EN
);

    localparam int             CW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD);
    localparam bit             HOLD_ON  = (MAX_HOLD != 0);

    arb_state_t      state;
    idx_t            pri;
    logic [CW-1:0]   cnt;

    logic            idle_found;
    idx_t            idle_win;
    logic            hand_found;
    idx_t            hand_win;
    logic [NREQ-1:0] others;
    idx_t            hand_start;

    logic            do_grant;
    logic            do_release;
    idx_t            grant_idx;

    // GNT is one-hot on the owner while in OWN, so masking it leaves only the contenders.
    assign others     = REQ & ~GNT;
    assign hand_start = SEL + idx_t'(1);

    rr_pick4 u_pick_idle (
        .req    (REQ),
        .start  (pri),
        .found  (idle_found),
        .winner (idle_win)
    );

    rr_pick4 u_pick_hand (
        .req    (others),
        .start  (hand_start),
        .found  (hand_found),
        .winner (hand_win)
    );

    always_comb begin
        do_grant   = 1'b0;
        do_release = 1'b0;
        grant_idx  = hand_win;
        if (state == IDLE) begin
            do_grant  = idle_found;
            grant_idx = idle_win;
        end else if (!REQ[SEL]) begin
            do_grant   = hand_found;
            do_release = !hand_found;
        end else if (HOLD_ON && (cnt == HOLD_LIM) && hand_found) begin
            do_grant = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            GNT   <= '0;
            SEL   <= '0;
            EN    <= 1'b0;
            pri   <= '0;
            cnt   <= '0;
        end else if (do_grant) begin
            // New owner (from idle, handover or preemption): SEL and GNT move together, EN stays high.
            state <= OWN;
            GNT   <= idx_onehot(grant_idx);
            SEL   <= grant_idx;
            EN    <= 1'b1;
            pri   <= grant_idx + idx_t'(1);
            cnt   <= CW'(1);
        end else if (do_release) begin
            state <= IDLE;
            GNT   <= '0;
            EN    <= 1'b0;
        end else if (state == OWN && HOLD_ON && cnt != HOLD_LIM) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_mux4x1_arb.sv
// Table-driven, scoreboard-checked bench for the round-robin mux arbiter.
module tb_mux4x1_arb;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       en;
    } vec_t;

    typedef struct {
        int         dut;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       en;
        string      tag;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] req_a, req_b, gnt_a, gnt_b;
    logic [1:0] sel_a, sel_b;
    logic       en_a, en_b;

    exp_t sb[$];
    vec_t tbl[19];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    mux4x1_arb #(.MAX_HOLD(8)) u_dut_a (
        .CLK (CLK), .RST_N (RST_N), .REQ (req_a),
        .GNT (gnt_a), .SEL (sel_a), .EN (en_a)
    );

    mux4x1_arb #(.MAX_HOLD(0)) u_dut_b (
        .CLK (CLK), .RST_N (RST_N), .REQ (req_b),
        .GNT (gnt_b), .SEL (sel_b), .EN (en_b)
    );

    task automatic check_out(input string tag, input int dut,
                             input logic [3:0] eg, input logic [1:0] es, input logic ee);
        logic [3:0] g;
        logic [1:0] s;
        logic       e;
        logic [3:0] one;
        one = 4'b0001;
        g = (dut == 0) ? gnt_a : gnt_b;
        s = (dut == 0) ? sel_a : sel_b;
        e = (dut == 0) ? en_a  : en_b;
        n_tests++;
        if (g !== eg || s !== es || e !== ee) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b sel=%0d en=%b, want gnt=%b sel=%0d en=%b",
                     tag, g, s, e, eg, es, ee);
        end
        n_tests++;
        if (e !== (|g) || (e && g !== (one << s))) begin
            n_fail++;
            $display("FAIL %s_invariant: got gnt=%b sel=%0d en=%b, want en==|gnt and gnt==1<<sel",
                     tag, g, s, e);
        end
    endtask

    task automatic step(input int dut, input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] es, input logic ee, input string tag);
        exp_t x;
        if (dut == 0) req_a = r; else req_b = r;
        x.dut = dut; x.gnt = eg; x.sel = es; x.en = ee; x.tag = tag;
        sb.push_back(x);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue, want one entry", tag);
        end else begin
            x = sb.pop_front();
            check_out(x.tag, x.dut, x.gnt, x.sel, x.en);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] one;
        int o;
        one   = 4'b0001;
        RST_N = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b0000;

        tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[6]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[8]  = '{4'b0101, 4'b0100, 2'd2, 1'b1};
        tbl[9]  = '{4'b0101, 4'b0100, 2'd2, 1'b1};
        tbl[10] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[12] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[13] = '{4'b1010, 4'b0010, 2'd1, 1'b1};
        tbl[14] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[15] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
        tbl[16] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        tbl[17] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[18] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

        #12;
        check_out("reset_a", 0, 4'b0000, 2'd0, 1'b0);
        check_out("reset_b", 1, 4'b0000, 2'd0, 1'b0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 19; i++)
            step(0, tbl[i].req, tbl[i].gnt, tbl[i].sel, tbl[i].en, $sformatf("vec%0d", i));

        // All four requesting from idle with the pointer at 3: eight cycles per owner, 3,0,1,2,3.
        for (int c = 0; c < 40; c++) begin
            o = (3 + c / 8) % 4;
            step(0, 4'b1111, one << o, 2'(o), 1'b1, $sformatf("fair%0d", c));
        end
        step(0, 4'b0000, 4'b0000, 2'd3, 1'b0, "fair_drop");

        for (int c = 0; c < 50; c++)
            step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, $sformatf("sole%0d", c));
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, "sole_drop");

        for (int c = 0; c < 20; c++)
            step(1, 4'b0011, 4'b0001, 2'd0, 1'b1, $sformatf("nolim%0d", c));
        step(1, 4'b0010, 4'b0010, 2'd1, 1'b1, "nolim_handover");
        step(1, 4'b0000, 4'b0000, 2'd1, 1'b0, "nolim_idle");

        step(1, 4'b0010, 4'b0010, 2'd1, 1'b1, "rst_grant_b");
        step(0, 4'b0010, 4'b0010, 2'd1, 1'b1, "rst_grant_a");
        #2;
        RST_N = 1'b0;
        #1;
        check_out("rst_async_a", 0, 4'b0000, 2'd0, 1'b0);
        check_out("rst_async_b", 1, 4'b0000, 2'd0, 1'b0);
        req_a = 4'b0000;
        req_b = 4'b0000;
        #2;
        RST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, $sformatf("post_rst%0d", c));
            check_out($sformatf("post_rst_b%0d", c), 1, 4'b0000, 2'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
